// File: rtl/regfile_pkg.sv
// regfile_pkg: default sizing constants and flattened-port slice helper for regfile_sb.
package regfile_pkg;
  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_DEPTH = 32;
  localparam int REGFILE_NUM_READ = 2;
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy vector with reserve/clear priority and reserve_stall decode.
module regfile_scoreboard #(
  parameter int DEPTH = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_address,
  input  logic              reserve_enable,
  input  logic [ADDR_W-1:0] reserve_address,
  output logic [DEPTH-1:0]  busy,
  output logic              reserve_stall
);
  logic [DEPTH-1:0] one, keep, set_v, clr_v;
  assign one = {{(DEPTH-1){1'b0}}, 1'b1};
  assign keep = ZERO_REG != 0 ? ~one : '1;
  // A write landing on the same register this cycle frees it, so the reserve need not wait.
  assign reserve_stall = reserve_enable && busy[reserve_address] &&
                         !(write_enable && write_address == reserve_address);
  assign set_v = (reserve_enable && !reserve_stall) ? (one << reserve_address) & keep : '0;
  assign clr_v = write_enable ? one << write_address : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= (busy & ~clr_v) | set_v;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with write-pending scoreboard.
// Define REGFILE_BYPASS_EN to forward writeback data to same-cycle readers.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int DEPTH = REGFILE_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_READ = REGFILE_NUM_READ,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_READ*ADDR_W-1:0] read_address,
  output logic [NUM_READ*DATA_W-1:0] read_data,
  output logic [NUM_READ-1:0]        read_busy,
  input  logic                       write_enable,
  input  logic [ADDR_W-1:0]          write_address,
  input  logic [DATA_W-1:0]          write_data,
  input  logic                       reserve_enable,
  input  logic [ADDR_W-1:0]          reserve_address,
  output logic                       reserve_stall
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  regfile_scoreboard #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .write_enable(write_enable),
    .write_address(write_address),
    .reserve_enable(reserve_enable),
    .reserve_address(reserve_address),
    .busy(busy),
    .reserve_stall(reserve_stall)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (write_enable && !(ZERO_REG != 0 && write_address == '0)) mem[write_address] <= write_data;
  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic zero, byp;
    assign addr = read_address[slice_lo(p, ADDR_W) +: ADDR_W];
    assign zero = ZERO_REG != 0 && addr == '0;
`ifdef REGFILE_BYPASS_EN
    // Gated by rst_n so a writeback strobe cannot leak through while in reset.
    assign byp = rst_n && write_enable && write_address == addr && !zero;
`else
    assign byp = 1'b0;
`endif
    assign read_data[slice_lo(p, DATA_W) +: DATA_W] = zero ? '0 : byp ? write_data : mem[addr];
    assign read_busy[p] = !zero && !byp && busy[addr];
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb with directed and random traffic against an array model.
module tb_regfile_sb;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR*AW-1:0] read_address;
  logic [NR*DW-1:0] read_data;
  logic [NR-1:0] read_busy;
  logic write_enable, reserve_enable, reserve_stall;
  logic [AW-1:0] write_address, reserve_address;
  logic [DW-1:0] write_data;
  always #5 clk = ~clk;
  regfile_sb dut (
    .clk(clk),
    .rst_n(rst_n),
    .read_address(read_address),
    .read_data(read_data),
    .read_busy(read_busy),
    .write_enable(write_enable),
    .write_address(write_address),
    .write_data(write_data),
    .reserve_enable(reserve_enable),
    .reserve_address(reserve_address),
    .reserve_stall(reserve_stall)
  );
  typedef struct {
    logic [NR*DW-1:0] data;
    logic [NR-1:0] busy;
    logic stall;
    string tag;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] m_data [32];
  logic m_busy [32];
  string cur_tag = "reset";
  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_data[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction
  function automatic logic model_stall();
    return reserve_enable && m_busy[reserve_address] &&
           !(write_enable && write_address == reserve_address);
  endfunction
  // Register 0 is constant zero; a write frees its register, an accepted reserve then marks it pending.
  function automatic void model_clock();
    logic s;
    s = model_stall();
    if (write_enable && write_address != 0) begin
      m_data[write_address] = write_data;
      m_busy[write_address] = 1'b0;
    end
    if (reserve_enable && !s && reserve_address != 0) m_busy[reserve_address] = 1'b1;
  endfunction
  function automatic void push_exp();
    exp_t e;
    logic [AW-1:0] a;
    e.tag = cur_tag;
    e.stall = rst_n ? model_stall() : 1'b0;
    for (int p = 0; p < NR; p++) begin
      a = read_address[p*AW +: AW];
      e.data[p*DW +: DW] = m_data[a];
      e.busy[p] = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (write_enable && write_address == a) begin
        e.data[p*DW +: DW] = write_data;
        e.busy[p] = 1'b0;
      end
`endif
      if (!rst_n || a == 0) begin
        e.data[p*DW +: DW] = '0;
        e.busy[p] = 1'b0;
      end
    end
    q.push_back(e);
  endfunction
  task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int p = 0; p < NR; p++) begin
        chk($sformatf("%s data%0d", e.tag, p), read_data[p*DW +: DW], e.data[p*DW +: DW]);
        chk($sformatf("%s busy%0d", e.tag, p), DW'(read_busy[p]), DW'(e.busy[p]));
      end
      chk($sformatf("%s stall", e.tag), DW'(reserve_stall), DW'(e.stall));
    end
  end
  task automatic drive(input string tag, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic r, input logic [AW-1:0] ra);
    read_address = {a1, a0};
    write_enable = w;
    write_address = wa;
    write_data = wd;
    reserve_enable = r;
    reserve_address = ra;
    cur_tag = tag;
  endtask
  task automatic step(input string tag, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic r, input logic [AW-1:0] ra);
    @(posedge clk);
    if (rst_n) model_clock();
    #1;
    drive(tag, a0, a1, w, wa, wd, r, ra);
    push_exp();
  endtask
  initial begin
    model_reset();
    drive("reset", 5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    #1 push_exp();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) step("rd_all", 5'(2*i), 5'(2*i+1), 1'b0, 5'd0, '0, 1'b0, 5'd0);
    step("wr5", 5'd5, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    step("rd5", 5'd5, 5'd5, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    step("wr0", 5'd0, 5'd5, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
    step("rd0", 5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    step("rsv7", 5'd7, 5'd7, 1'b0, 5'd0, '0, 1'b1, 5'd7);
    step("rsv7_again", 5'd7, 5'd7, 1'b0, 5'd0, '0, 1'b1, 5'd7);
    step("wr7", 5'd7, 5'd7, 1'b1, 5'd7, 32'h55, 1'b0, 5'd0);
    step("rd7", 5'd7, 5'd7, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    step("rsv_wr9", 5'd9, 5'd9, 1'b1, 5'd9, 32'hA5, 1'b1, 5'd9);
    step("rd9", 5'd9, 5'd9, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    step("rsv_wr9_busy", 5'd9, 5'd7, 1'b1, 5'd9, 32'hB6, 1'b1, 5'd9);
    step("rd9_again", 5'd9, 5'd7, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    step("wr_rsv_split", 5'd10, 5'd11, 1'b1, 5'd10, 32'hC3, 1'b1, 5'd11);
    step("rd_split", 5'd10, 5'd11, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    step("pre3", 5'd3, 5'd3, 1'b1, 5'd3, 32'h11, 1'b1, 5'd12);
    step("byp3", 5'd0, 5'd3, 1'b1, 5'd3, 32'h77, 1'b0, 5'd0);
    step("after3", 5'd0, 5'd3, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    step("rsv0", 5'd0, 5'd12, 1'b0, 5'd0, '0, 1'b1, 5'd0);
    step("rd_rsv0", 5'd0, 5'd12, 1'b0, 5'd0, '0, 1'b1, 5'd0);
    @(posedge clk);
    model_clock();
    #1;
    drive("mid_rst", 5'd5, 5'd12, 1'b1, 5'd5, 32'hFFFF0000, 1'b1, 5'd12);
    #1 rst_n = 1'b0;
    model_reset();
    push_exp();
    step("in_rst", 5'd5, 5'd9, 1'b1, 5'd9, 32'h1, 1'b1, 5'd9);
    @(negedge clk);
    #1 rst_n = 1'b1;
    write_enable = 1'b0;
    reserve_enable = 1'b0;
    step("post_rst", 5'd5, 5'd12, 1'b0, 5'd0, '0, 1'b1, 5'd12);
    repeat (400)
      step("rand", 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
